// File: rtl/uart_pkg.sv
// Shared state encoding, parity-mode constants and bit-timing helper for the UART receiver.
// Latency: none (declarations only). Backpressure: none.
// The optional output FIFO (macro UART_RX_FIFO_EN) is selected in uart_rx_param, not here.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through synchronous FIFO holding received words with their error flags.
// Latency: a write is visible on rd_dat / !empty the cycle after it is accepted.
// Backpressure: writes are refused when full unless a read frees a slot in the same cycle.
module uart_rx_fifo
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign do_rd  = rd_en && !empty;
    // A read in the same cycle frees the slot, so a full FIFO can still take the write.
    assign do_wr  = wr_en && (!full || do_rd);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling of data/parity/stop bits into a valid/ready stream.
// Latency: 3 clk line-to-start-detect; word valid 2 clk after the last stop-bit sample.
// Backpressure: holding register (or FIFO with UART_RX_FIFO_EN); a word arriving to full storage is dropped with an overrun pulse.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int TW  = $clog2(CPB);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int W   = DATA_BITS + 2;

    localparam logic [TW-1:0] T_FULL    = TW'(CPB - 1);
    localparam logic [TW-1:0] T_HALF    = TW'(CPB / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          ODD_PAR   = (PARITY == PAR_ODD);

    generate
        if (CPB < 4) begin : g_bad_cpb
            $error("uart_rx_param: CLK_HZ/BAUD must be at least 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_rx_param: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_rx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_rx_param: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_rx_param: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    // Two synchroniser flops plus a history flop for edge detection; all reset to idle-high.
    logic line_s1;
    logic line_sync;
    logic line_hist;

    always_ff @(posedge CLK) begin
        if (RST) begin
            line_s1   <= 1'b1;
            line_sync <= 1'b1;
            line_hist <= 1'b1;
        end else begin
            line_s1   <= UART_RX;
            line_sync <= line_s1;
            line_hist <= line_sync;
        end
    end

    rx_state_t            state;
    logic [TW-1:0]        timer;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 ferr;
    logic                 perr;
    logic                 push_vld;
    logic [W-1:0]         push_dat;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            ferr     <= 1'b0;
            perr     <= 1'b0;
            push_vld <= 1'b0;
            push_dat <= '0;
        end else begin
            push_vld <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (line_hist && !line_sync) begin
                        state <= ST_START;
                        timer <= T_HALF;
                    end
                end
                ST_START: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else if (line_sync) begin
                        state <= ST_IDLE;
                    end else begin
                        state   <= ST_DATA;
                        timer   <= T_FULL;
                        bit_cnt <= '0;
                        ferr    <= 1'b0;
                        perr    <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else begin
                        timer <= T_FULL;
                        shift <= {line_sync, shift[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt  <= '0;
                            stop_cnt <= 1'b0;
                            state    <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else begin
                        timer <= T_FULL;
                        perr  <= line_sync ^ (^shift) ^ ODD_PAR;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else begin
                        timer <= T_FULL;
                        if (stop_cnt == STOP_LAST) begin
                            stop_cnt <= 1'b0;
                            push_vld <= 1'b1;
                            push_dat <= {shift, ferr | !line_sync, perr};
                            state    <= (ferr || !line_sync) ? ST_BREAK : ST_IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                            ferr     <= ferr | !line_sync;
                        end
                    end
                end
                ST_BREAK: begin
                    // Wait out a held-low line so it cannot look like a new start edge.
                    if (line_sync) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [W-1:0] out_word;
    logic         ovr_q;

    assign rx_data    = out_word[W-1:2];
    assign frame_err  = out_word[1];
    assign parity_err = out_word[0];
    assign overrun    = ovr_q;

`ifdef UART_RX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    uart_rx_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (CLK),
        .rst    (RST),
        .wr_en  (push_vld),
        .wr_dat (push_dat),
        .rd_en  (rx_ready),
        .rd_dat (out_word),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign rx_valid = !fifo_empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= push_vld && fifo_full && !rx_ready;
        end
    end
`else
    logic hold_vld;

    assign rx_valid = hold_vld;

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_word <= '0;
            hold_vld <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (push_vld && hold_vld && !rx_ready) begin
                ovr_q <= 1'b1;
            end else if (push_vld) begin
                out_word <= push_dat;
                hold_vld <= 1'b1;
            end else if (hold_vld && rx_ready) begin
                hold_vld <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and an 8E1 instance at 16 clocks per bit.
module tb_uart_rx_param;

    localparam int CPB = 16;

`ifdef UART_RX_FIFO_EN
    localparam int EXP_OVR   = 1;
    localparam int EXP_DRAIN = 4;
`else
    localparam int EXP_OVR   = 4;
    localparam int EXP_DRAIN = 1;
`endif

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       line_a = 1'b1;
    logic       line_p = 1'b1;
    logic       ready  = 1'b0;
    logic [7:0] data_a, data_p;
    logic       vld_a, vld_p, fe_a, fe_p, pe_a, pe_p, ov_a, ov_p;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut (
        .CLK(clk), .RST(rst), .UART_RX(line_a),
        .rx_data(data_a), .rx_valid(vld_a), .rx_ready(ready),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a)
    );

    uart_rx_param #(
        .CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_p (
        .CLK(clk), .RST(rst), .UART_RX(line_p),
        .rx_data(data_p), .rx_valid(vld_p), .rx_ready(ready),
        .frame_err(fe_p), .parity_err(pe_p), .overrun(ov_p)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ovr_a = 0;
    int   ovr_p = 0;
    logic sel   = 1'b0;

    logic [7:0] m_data;
    logic       m_vld, m_fe, m_pe;
    assign m_data = sel ? data_p : data_a;
    assign m_vld  = sel ? vld_p  : vld_a;
    assign m_fe   = sel ? fe_p   : fe_a;
    assign m_pe   = sel ? pe_p   : pe_a;

    always @(negedge clk) begin
        if (ov_a) ovr_a++;
        if (ov_p) ovr_p++;
    end

    typedef struct {
        logic       sel;
        logic [7:0] d;
        logic       use_par;
        logic       pbit;
        logic       stopv;
        logic [7:0] exp_d;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_line(input logic v);
        if (sel) line_p = v;
        else     line_a = v;
    endtask

    task automatic hold_bits(input int n);
        repeat (n * CPB) @(negedge clk);
    endtask

    // Leaves the line at the stop level so a caller can extend a low stop bit.
    task automatic send(input logic [7:0] d, input logic use_par, input logic pbit, input logic stopv);
        set_line(1'b0);
        hold_bits(1);
        for (int i = 0; i < 8; i++) begin
            set_line(d[i]);
            hold_bits(1);
        end
        if (use_par) begin
            set_line(pbit);
            hold_bits(1);
        end
        set_line(stopv);
        hold_bits(1);
    endtask

    task automatic wait_vld(input string name);
        int n = 0;
        while (!m_vld && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(m_vld), 1);
    endtask

    task automatic pop();
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

        // Reset state, both during and just after reset.
        repeat (4) @(negedge clk);
        chk("rst_valid", int'(vld_a), 0);
        chk("rst_data", int'(data_a), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_frame_err", int'(fe_a), 0);
        chk("rst_parity_err", int'(pe_a), 0);
        chk("rst_overrun", int'(ov_a), 0);
        chk("rst_valid_p", int'(vld_p), 0);

        // Short low glitch must be rejected as a false start, then 0x3C received.
        sel = 1'b0;
        set_line(1'b0);
        repeat (4) @(negedge clk);
        set_line(1'b1);
        hold_bits(3);
        chk("glitch_no_valid", int'(vld_a), 0);
        send(8'h3C, 1'b0, 1'b0, 1'b1);
        hold_bits(1);
        wait_vld("glitch_next_valid");
        chk("glitch_next_data", int'(data_a), 'h3C);
        chk("glitch_next_fe", int'(fe_a), 0);
        pop();

        for (int i = 0; i < NV; i++) begin
            sel = vecs[i].sel;
            send(vecs[i].d, vecs[i].use_par, vecs[i].pbit, vecs[i].stopv);
            if (!vecs[i].stopv) begin
                repeat (40) @(negedge clk);
                set_line(1'b1);
            end
            hold_bits(1);
            wait_vld($sformatf("v%0d_valid", i));
            chk($sformatf("v%0d_data", i), int'(m_data), int'(vecs[i].exp_d));
            chk($sformatf("v%0d_frame_err", i), int'(m_fe), int'(vecs[i].exp_fe));
            chk($sformatf("v%0d_parity_err", i), int'(m_pe), int'(vecs[i].exp_pe));
            repeat (20) @(negedge clk);
            chk($sformatf("v%0d_held_valid", i), int'(m_vld), 1);
            chk($sformatf("v%0d_held_data", i), int'(m_data), int'(vecs[i].exp_d));
            pop();
            chk($sformatf("v%0d_popped", i), int'(m_vld), 0);
        end

        chk("no_overrun_a", ovr_a, 0);
        chk("no_overrun_p", ovr_p, 0);

        // Five words with the consumer stalled.
        sel   = 1'b0;
        ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send(8'(k), 1'b0, 1'b0, 1'b1);
        end
        hold_bits(2);
        chk("overrun_pulses", ovr_a, EXP_OVR);
        for (int k = 1; k <= EXP_DRAIN; k++) begin
            wait_vld($sformatf("drain%0d_valid", k));
            chk($sformatf("drain%0d_data", k), int'(data_a), k);
            pop();
        end
        repeat (4) @(negedge clk);
        chk("drain_empty", int'(vld_a), 0);

        // Reset in the middle of the data bits of 0xFF, then 0x81.
        set_line(1'b0);
        hold_bits(1);
        set_line(1'b1);
        hold_bits(3);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold_bits(8);
        chk("midrst_no_valid", int'(vld_a), 0);
        chk("midrst_no_overrun", ovr_a, EXP_OVR);
        send(8'h81, 1'b0, 1'b0, 1'b1);
        hold_bits(1);
        wait_vld("after_rst_valid");
        chk("after_rst_data", int'(data_a), 'h81);
        chk("after_rst_fe", int'(fe_a), 0);
        pop();
        hold_bits(2);
        chk("after_rst_single", int'(vld_a), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, successor to the fixed 8N1 receive controller. Synchronises the asynchronous `UART_RX` line, detects and validates the start bit, samples DATA_BITS data bits, an optional parity bit and STOP_BITS stop bits at mid-bit, and delivers each word with its error flags through a valid/ready stream. It sits between the board pin and the echo/command logic.

## Interface
- `CLK_HZ`, 100_000_000, core clock frequency in Hz
- `BAUD`, 115_200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be ≥ 4, elaboration error otherwise)
- `DATA_BITS`, 8, data bits per word, legal 5..9
- `PARITY`, 0, 0 = none, 1 = even, 2 = odd
- `STOP_BITS`, 1, legal 1 or 2
- `FIFO_DEPTH`, 4, output FIFO entries, power of two ≥ 2 (used only with UART_RX_FIFO_EN)
- `CLK` in 1 core clock; all logic on rising edge
- `RST` in 1 synchronous, active-high reset
- `UART_RX` in 1 asynchronous serial input, idle high
- `rx_data` out DATA_BITS received word, LSB first on the line
- `rx_valid` out 1 word available
- `rx_ready` in 1 consumer accepts; transfer when `rx_valid && rx_ready`
- `frame_err` out 1 qualifies `rx_data`: a stop bit sampled low
- `parity_err` out 1 qualifies `rx_data`: parity mismatch (always 0 when PARITY = 0)
- `overrun` out 1 one-cycle pulse: completed word dropped because storage was full

## Operation
- `UART_RX` passes through a 2-FF synchroniser plus one history stage; a falling edge (history 1, current 0) in IDLE starts reception.
- States: IDLE → START → DATA → PARITY (skipped if PARITY = 0) → STOP → IDLE; BREAK entered from STOP on frame error.
- Bit timer counts down; loaded with CLKS_PER_BIT/2 − 1 on start edge, CLKS_PER_BIT − 1 after every sample.
- START: at mid-bit, line high → false start, return to IDLE, nothing pushed; low → DATA.
- DATA: shift sampled bit into MSB of shift register, counter 0..DATA_BITS−1; after last bit → PARITY or STOP.
- PARITY: compare sampled bit with XOR of data (even) or its inverse (odd).
- STOP: sample each stop bit; any low sample sets frame_err. After last stop sample push {data, frame_err, parity_err}. If frame_err, go BREAK and stay until synchronised line high, then IDLE; otherwise IDLE directly.
- Push when storage full: word discarded, `overrun` pulses in the push cycle; stored words untouched.
- Reset mid-frame: state IDLE, timer/counters cleared, storage emptied; partial word lost, no push.

## Timing
- Reset values: `rx_data` 0, `rx_valid` 0, `frame_err` 0, `parity_err` 0, `overrun` 0.
- Line-to-detect latency: 3 CLK (synchroniser + history).
- `rx_valid` rises the cycle after the push when storage was empty; data and flags stable while `rx_valid && !rx_ready`.
- Simultaneous push and pop on a full FIFO: pop first, push accepted, no overrun.
- Start edge is ignored in any state other than IDLE.

## Configuration
- `UART_RX_FIFO_EN` defined: FIFO_DEPTH-entry FIFO between receiver and outputs; overrun only when all entries held.
- Undefined: single holding register; overrun when a word completes while `rx_valid && !rx_ready` in that cycle. FIFO_DEPTH ignored.

## Structure
- Package `uart_pkg`: state enum (IDLE, START, DATA, PARITY, STOP, BREAK), parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD), CLKS_PER_BIT helper function.
- Sub-module `uart_rx_fifo`: synchronous FIFO, width DATA_BITS+2, first-word-fall-through, full/empty flags; instantiated only under UART_RX_FIFO_EN.

## Test plan
- CLK_HZ=1_600_000, BAUD=100_000 (16 clks/bit), 8N1, send 0xA5 → `rx_data`=0xA5, both error flags 0, `rx_valid` high until `rx_ready`.
- 0 low pulse of 4 clks on idle line → no push, `rx_valid` stays 0, receiver accepts 0x3C sent immediately after.
- PARITY=1, send 0x07 with parity bit 0 → `rx_data`=0x07, `parity_err`=1; with parity bit 1 → `parity_err`=0.
- Send 0x55 with stop bit low, line held low 40 clks, then 0x12 → first word `frame_err`=1, second 0x12 clean.
- FIFO_DEPTH=4, `rx_ready`=0, send 5 words 0x01..0x05 → `overrun` pulses once on fifth; drain returns 0x01..0x04.
- Assert `RST` mid-DATA of 0xFF, release, send 0x81 → only 0x81 delivered.
